enable_debouncer: RTL and testbench

ENABLE_DEBOUNCER -- requirements
Module: enable_debouncer

---
 rtl/enable_debouncer_pkg.sv | 23 ++
 rtl/enable_debouncer_sync_2ff.sv | 29 ++
 rtl/enable_debouncer.sv | 120 ++++++++++++
 tb/tb_enable_debouncer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/enable_debouncer_pkg.sv
// enable_debouncer_pkg: shared FSM state encoding and default debounce length.
// Rev 1.0
`default_nettype none

package enable_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } db_state_t;

  localparam int C_DEFAULT_DEBOUNCE_CYCLES = 4;

  // Accepted level is high in both "held" states, including while a release is being qualified.
  function automatic logic is_level_high(input db_state_t s);
    return (s == PRESSED) || (s == CHECK_RELEASE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/enable_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input, async active-low reset.
// Rev 1.0
`default_nettype none

module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/enable_debouncer.sv
// enable_debouncer: synchronized, FSM-debounced push button producing enable/pulse/level.
// Rev 1.0 -- define ENABLE_TOGGLE_EN for a press-on/press-off enable latch.
`default_nettype none

module enable_debouncer
  import enable_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = C_DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic buttonIn,
  output logic enable,
  output logic pressPulse,
  output logic debouncedLevel
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic                 w_synced;
  db_state_t            r_state;
  db_state_t            w_next_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_accept_press;
  logic                 w_level_next;
  logic                 w_enable_next;
  logic                 r_enable;
  logic                 r_pulse;
  logic                 r_level;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (buttonIn),
    .q     (w_synced)
  );

  // Saturating increment: the counter never wraps even if the compare is ever missed.
  assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_accept_press = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_synced) begin
          w_next_state = CHECK_PRESS;
          w_next_cnt   = '0;
        end
      end
      CHECK_PRESS: begin
        if (!w_synced) begin
          w_next_state = RELEASED;
        end else if (r_cnt == C_CNT_LAST) begin
          w_next_state   = PRESSED;
          w_accept_press = 1'b1;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!w_synced) begin
          w_next_state = CHECK_RELEASE;
          w_next_cnt   = '0;
        end
      end
      CHECK_RELEASE: begin
        if (w_synced) begin
          w_next_state = PRESSED;
        end else if (r_cnt == C_CNT_LAST) begin
          w_next_state = RELEASED;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_next_state = RELEASED;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  assign w_level_next = is_level_high(w_next_state);

`ifdef ENABLE_TOGGLE_EN
  assign w_enable_next = r_enable ^ w_accept_press;
`else
  assign w_enable_next = w_level_next;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= RELEASED;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_level  <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_pulse  <= w_accept_press;
      r_level  <= w_level_next;
      r_enable <= w_enable_next;
    end
  end

  assign enable         = r_enable;
  assign pressPulse     = r_pulse;
  assign debouncedLevel = r_level;

endmodule

`default_nettype wire

// File: tb/tb_enable_debouncer.sv
// tb_enable_debouncer: table vectors, directed corner sequences and random stimulus vs a run-length model.
// Rev 1.0
`default_nettype none

module tb_enable_debouncer;

  localparam int D = 4;

  logic clock;
  logic reset;
  logic buttonIn;
  logic enable;
  logic pressPulse;
  logic debouncedLevel;

  int n_tests = 0;
  int n_fail  = 0;

  enable_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .buttonIn       (buttonIn),
    .enable         (enable),
    .pressPulse     (pressPulse),
    .debouncedLevel (debouncedLevel)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  // Reference model: raw samples delayed two edges, then a run of D+1 consecutive
  // synchronized samples disagreeing with the accepted level flips it.
  logic m_s1, m_s2, m_level, m_pulse, m_en;
  int   m_run;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_en = 0; m_run = 0;
  endtask

  task automatic model_edge(input logic btn);
    logic samp;
    samp    = m_s2;
    m_s2    = m_s1;
    m_s1    = btn;
    m_pulse = 0;
    if (samp != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = samp;
        m_run   = 0;
        m_pulse = samp;
      end
    end else begin
      m_run = 0;
    end
`ifdef ENABLE_TOGGLE_EN
    m_en = m_en ^ m_pulse;
`else
    m_en = m_level;
`endif
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  // Called just after a negedge: drive, let one rising edge pass, compare at the next negedge.
  task automatic step(input logic rst_v, input logic btn_v);
    reset    = rst_v;
    buttonIn = btn_v;
    if (!rst_v) model_reset();
    @(posedge clock);
    if (rst_v) model_edge(btn_v);
    @(negedge clock);
    chk("model_pulse", pressPulse, m_pulse);
    chk("model_level", debouncedLevel, m_level);
    chk("model_enable", enable, m_en);
  endtask

  typedef struct {
    logic rst_n;
    logic btn;
    logic pulse;
    logic level;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic b, input logic p, input logic l);
    vec_t v;
    v.rst_n = r; v.btn = b; v.pulse = p; v.level = l;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic e_en;
    int   lat;
    int   pulses;
    int   pulse_step;

    reset    = 1'b0;
    buttonIn = 1'b1;
    model_reset();
    @(negedge clock);

    // Held button through reset, clean press, clean release, then a 2-cycle glitch.
    add(3, 0, 1, 0, 0);
    add(6, 1, 1, 0, 0);
    add(1, 1, 1, 1, 1);
    add(1, 1, 1, 0, 1);
    add(6, 1, 0, 0, 1);
    add(2, 1, 0, 0, 0);
    add(2, 1, 1, 0, 0);
    add(8, 1, 0, 0, 0);

    e_en = 1'b0;
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].btn);
      if (!vecs[i].rst_n) e_en = 1'b0;
`ifdef ENABLE_TOGGLE_EN
      else e_en = e_en ^ vecs[i].pulse;
`else
      else e_en = vecs[i].level;
`endif
      chk("vec_pulse", pressPulse, vecs[i].pulse);
      chk("vec_level", debouncedLevel, vecs[i].level);
      chk("vec_enable", enable, e_en);
    end

    // Reset landing in CHECK_PRESS with counter at 2.
    for (int k = 0; k < 5; k++) step(1, 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_chk_pulse", pressPulse, 1'b0);
    chk("rst_chk_level", debouncedLevel, 1'b0);
    chk("rst_chk_enable", enable, 1'b0);
    @(negedge clock);
    step(0, 1);

    // Held button after reset release must be accepted after a full debounce.
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step(1, 1);
      if (pressPulse) lat = k;
    end
    chk_int("rst_press_latency", lat, 6, 7);

    // Asynchronous reset while pressed clears outputs without waiting for an edge.
    step(1, 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pressed_level", debouncedLevel, 1'b0);
    chk("rst_pressed_enable", enable, 1'b0);
    chk("rst_pressed_pulse", pressPulse, 1'b0);
    @(negedge clock);
    step(0, 0);
    for (int k = 0; k < 4; k++) step(1, 0);

    // Bounce every cycle for 10 cycles, then stable high.
    pulses = 0;
    pulse_step = -1;
    for (int k = 0; k < 26; k++) begin
      step(1, (k >= 10) ? 1'b1 : ((k % 2) == 0));
      if (pressPulse) begin
        pulses++;
        pulse_step = k;
      end
    end
    chk_int("bounce_pulse_count", pulses, 1, 1);
    chk_int("bounce_latency", pulse_step - 10, 6, 7);

    // Long hold, then release: a release never pulses.
    for (int k = 0; k < 20; k++) step(1, 1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step(1, 0);
      if (pressPulse) pulses++;
    end
    chk_int("release_pulses", pulses, 0, 0);
    chk("release_level", debouncedLevel, 1'b0);

    // Three clean presses (enable latch toggles on each when configured).
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 10; k++) step(1, 1);
      for (int k = 0; k < 10; k++) step(1, 0);
    end

    // Random runs of random length, with occasional reset pulses.
    for (int r = 0; r < 300; r++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(1, 0));
      len = int'($urandom_range(9, 1));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(59, 0) == 0) step(0, lvl);
        else step(1, lvl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
